// File: rtl/reg_bank8_wr.sv
// reg_bank8_wr: write side of the 8 x DATA_W register bank with a one-register-per-cycle clear sweep.
// Optional {N,Z,P} flags of the last accepted write are enabled by defining REGBANK_NZP_EN.
module reg_bank8_wr #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_req,
    output logic              busy,
`ifdef REGBANK_NZP_EN
    output logic [2:0]        nzp,
`endif
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q1,
    output logic [DATA_W-1:0] q2,
    output logic [DATA_W-1:0] q3,
    output logic [DATA_W-1:0] q4,
    output logic [DATA_W-1:0] q5,
    output logic [DATA_W-1:0] q6,
    output logic [DATA_W-1:0] q7
);
    typedef enum logic {IDLE, SWEEP} stateT;
    stateT             state;
    logic [2:0]        sweepCnt;
    logic [DATA_W-1:0] regFile [8];
    logic              accept;
    // A clear request in IDLE takes priority over a same-cycle write, so it also blocks ready.
    assign wr_ready = (state == IDLE) && !clr_req;
    assign accept   = wr_en && wr_ready;
    assign q0 = regFile[0];
    assign q1 = regFile[1];
    assign q2 = regFile[2];
    assign q3 = regFile[3];
    assign q4 = regFile[4];
    assign q5 = regFile[5];
    assign q6 = regFile[6];
    assign q7 = regFile[7];
    // Sweep control: one pass of eight cycles, ended by the terminal count rather than a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sweepCnt <= 3'd0;
        end else if (state == IDLE) begin
            if (clr_req) begin
                state    <= SWEEP;
                busy     <= 1'b1;
                sweepCnt <= 3'd0;
            end
        end else begin
            sweepCnt <= sweepCnt + 3'd1;
            if (sweepCnt == 3'd7) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end
    // Storage: the sweep zeroes the counted register; otherwise an accepted write lands in its target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regFile[i] <= '0;
        end else if (state == SWEEP) begin
            regFile[sweepCnt] <= '0;
        end else if (accept) begin
            regFile[wr_sel] <= wr_data;
        end
    end
`ifdef REGBANK_NZP_EN
    // Sign/zero flags track accepted writes only; sweep clears leave them untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) nzp <= 3'b010;
        else if (accept) nzp <= {wr_data[DATA_W-1], wr_data == '0, !wr_data[DATA_W-1] && wr_data != '0};
    end
`endif
endmodule

// File: tb/tb_reg_bank8_wr.sv
// tb_reg_bank8_wr: table-driven, hand-sequenced and random checks of reg_bank8_wr against a behavioural model.
module tb_reg_bank8_wr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_sel = 3'd0;
    logic [15:0] wr_data = 16'h0;
    logic        clr_req = 1'b0;
    logic        wr_ready;
    logic        busy;
    logic [15:0] q [8];
`ifdef REGBANK_NZP_EN
    logic [2:0]  nzp;
`endif

    reg_bank8_wr #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr_req(clr_req), .busy(busy),
`ifdef REGBANK_NZP_EN
        .nzp(nzp),
`endif
        .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]), .q4(q[4]), .q5(q[5]), .q6(q[6]), .q7(q[7])
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int totCnt = 0;

    // Reference model: register contents, remaining sweep clears and next register to clear.
    logic [15:0] mq [8];
    int          left = 0;
    int          idx = 0;
    logic [2:0]  mnzp = 3'b010;
    logic        modelValid = 1'b0;
    logic        sampReady;

    typedef struct {
        logic        rstN;
        logic        en;
        logic [2:0]  sel;
        logic [15:0] data;
        logic        clr;
        logic        expReady;
        logic        expBusy;
        logic [2:0]  qIdx;
        logic [15:0] expQ;
    } vecT;
    vecT vt [$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        totCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // One clock: apply inputs, check ready mid-cycle, advance model at the edge, check outputs after it.
    task automatic cyc(input logic r, input logic e, input logic [2:0] s, input logic [15:0] d, input logic c);
        rst_n = r; wr_en = e; wr_sel = s; wr_data = d; clr_req = c;
        @(negedge clk);
        sampReady = wr_ready;
        if (modelValid) chk("wr_ready", {15'd0, wr_ready}, {15'd0, (left == 0) && !c});
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 8; i++) mq[i] = 16'h0;
            left = 0; idx = 0; mnzp = 3'b010;
        end else if (left > 0) begin
            mq[idx] = 16'h0; idx++; left--;
        end else if (c) begin
            left = 8; idx = 0;
        end else if (e) begin
            mq[s] = d;
            mnzp = ($signed(d) < 0) ? 3'b100 : (d == 16'h0) ? 3'b010 : 3'b001;
        end
        modelValid = 1'b1;
        #1;
        chk("busy", {15'd0, busy}, {15'd0, left > 0});
        for (int i = 0; i < 8; i++) chk($sformatf("q%0d", i), q[i], mq[i]);
`ifdef REGBANK_NZP_EN
        chk("nzp", {13'd0, nzp}, {13'd0, mnzp});
`endif
    endtask

    function automatic vecT mk(input logic r, e, input logic [2:0] s, input logic [15:0] d,
                               input logic c, er, eb, input logic [2:0] qi, input logic [15:0] eq);
        vecT v;
        v.rstN = r; v.en = e; v.sel = s; v.data = d; v.clr = c;
        v.expReady = er; v.expBusy = eb; v.qIdx = qi; v.expQ = eq;
        return v;
    endfunction

    initial begin
        int k;
        int lowCnt;
        int busyCnt;
        // Table: sequential writes, back-to-back same-register writes, write colliding with a clear, full sweep.
        for (int i = 0; i < 8; i++) vt.push_back(mk(1, 1, 3'(i), 16'h1000 + 16'(i), 0, 1, 0, 3'(i), 16'h1000 + 16'(i)));
        vt.push_back(mk(1, 1, 3'd3, 16'hAAAA, 0, 1, 0, 3'd3, 16'hAAAA));
        vt.push_back(mk(1, 1, 3'd3, 16'h5555, 0, 1, 0, 3'd3, 16'h5555));
        vt.push_back(mk(1, 0, 3'd0, 16'h0, 0, 1, 0, 3'd2, 16'h1002));
        vt.push_back(mk(1, 0, 3'd0, 16'h0, 0, 1, 0, 3'd4, 16'h1004));
        vt.push_back(mk(1, 1, 3'd1, 16'h1234, 1, 0, 1, 3'd1, 16'h1001));
        for (int i = 0; i < 8; i++) vt.push_back(mk(1, 0, 3'd0, 16'h0, 0, 0, i < 7, 3'(i), 16'h0));
        vt.push_back(mk(1, 0, 3'd0, 16'h0, 0, 1, 0, 3'd1, 16'h0));

        cyc(0, 0, 3'd0, 16'h0, 0);
        cyc(0, 0, 3'd0, 16'h0, 0);
        chk("reset_ready", {15'd0, wr_ready}, 16'd1);
        foreach (vt[i]) begin
            cyc(vt[i].rstN, vt[i].en, vt[i].sel, vt[i].data, vt[i].clr);
            chk($sformatf("tbl%0d_ready", i), {15'd0, sampReady}, {15'd0, vt[i].expReady});
            chk($sformatf("tbl%0d_busy", i), {15'd0, busy}, {15'd0, vt[i].expBusy});
            chk($sformatf("tbl%0d_q", i), q[vt[i].qIdx], vt[i].expQ);
        end

        // Held write during a sweep: refused for the whole sweep, accepted once busy falls.
        cyc(1, 1, 3'd2, 16'h2222, 0);
        cyc(1, 1, 3'd5, 16'h7777, 0);
        cyc(1, 1, 3'd5, 16'hBEEF, 1);
        busyCnt = busy ? 1 : 0;
        lowCnt = 0;
        k = 0;
        while (busy && k < 20) begin
            cyc(1, 1, 3'd5, 16'hBEEF, 0);
            if (!sampReady) lowCnt++;
            if (busy) busyCnt++;
            k++;
        end
        chk("sweep_end", {15'd0, busy}, 16'd0);
        chk("busy_cycles", 16'(busyCnt), 16'd8);
        chk("ready_low_cycles", 16'(lowCnt), 16'd8);
        chk("q5_before_write", q[5], 16'h0);
        chk("q2_swept", q[2], 16'h0);
        cyc(1, 1, 3'd5, 16'hBEEF, 0);
        chk("held_write_ready", {15'd0, sampReady}, 16'd1);
        chk("q5_after_sweep", q[5], 16'hBEEF);

        // Reset in the middle of a sweep.
        cyc(1, 1, 3'd7, 16'h1111, 0);
        cyc(1, 0, 3'd0, 16'h0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 3'd0, 16'h0, 0);
        chk("mid_sweep_busy", {15'd0, busy}, 16'd1);
        chk("mid_sweep_q7", q[7], 16'h1111);
        cyc(0, 0, 3'd0, 16'h0, 0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_q5", q[5], 16'h0);
        chk("rst_q7", q[7], 16'h0);
        cyc(1, 0, 3'd0, 16'h0, 0);
        chk("rst_release_ready", {15'd0, sampReady}, 16'd1);

`ifdef REGBANK_NZP_EN
        // Flags follow accepted writes only; a sweep leaves them alone.
        cyc(1, 1, 3'd0, 16'h8000, 0);
        chk("nzp_neg", {13'd0, nzp}, 16'd4);
        cyc(1, 1, 3'd1, 16'h0000, 0);
        chk("nzp_zero", {13'd0, nzp}, 16'd2);
        cyc(1, 1, 3'd2, 16'h0001, 0);
        chk("nzp_pos", {13'd0, nzp}, 16'd1);
        cyc(1, 0, 3'd0, 16'h0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 1, 3'd3, 16'h8000, 0);
        chk("nzp_after_sweep", {13'd0, nzp}, 16'd1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 59) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
                $urandom_range(0, 19) == 0);

        $display("%0d/%0d checks passed", passCnt, totCnt);
        $finish;
    end
endmodule
